ccd_frame_capture: RTL and testbench

- Front-end capture stage that converts raw sensor timing (FVAL/LVAL/pixel data) into the framed pixel stream consumed by the Bayer-to-RGB stage and the image-processing top level.
- Generates registered pixel data, data-valid, frame-valid, X/Y coordinates and a frame counter.
- Adds a start/stop controller so capture begins and ends only on frame boundaries.
- Optionally checks frame geometry.

---
 rtl/ccd_frame_capture.sv | 175 +++++++++++++++++
 tb/tb_ccd_frame_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_frame_capture.sv
// Sensor front-end: registers FVAL/LVAL/pixel data and produces a framed pixel stream with X/Y and frame count.
// Capture starts and stops on frame boundaries. Define CCD_CAPTURE_GEOM_CHECK_EN to enable the frame geometry check.
module ccd_frame_capture #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 12
) (
    input  logic              CCD_PIXCLK,
    input  logic              iRst_n,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic              iStart,
    input  logic              iEnd,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic              oFval,
    output logic [15:0]       oX_Cont,
    output logic [15:0]       oY_Cont,
    output logic [31:0]       oFrame_Cont,
    output logic              oCapturing,
    output logic              oFrameErr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);

    if (H_ACTIVE < 2 || H_ACTIVE > 65536 || V_ACTIVE < 1) begin : g_param_check
        $error("ccd_frame_capture: H_ACTIVE must be 2..65536 and V_ACTIVE >= 1");
    end

    logic [DATA_W-1:0] rD_q;
    logic              rF_q, rL_q, pF_q;
    logic [1:0]        state_q, state_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [DATA_W-1:0] oDATA_q;
    logic              oDVAL_q, oFval_q;
    logic [15:0]       oX_q, oX_d, oY_q, oY_d;
    logic [31:0]       frm_q, frm_d;

    logic        frame_start, frame_end, cap_c, fval_c, dval_c, counted_end;
    logic [15:0] cur_x, cur_y;

    always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            rD_q <= '0;
            rF_q <= 1'b0;
            rL_q <= 1'b0;
            pF_q <= 1'b0;
        end else begin
            rD_q <= iDATA;
            rF_q <= iFVAL;
            rL_q <= iLVAL;
            pF_q <= rF_q;
        end
    end

    assign frame_start = rF_q & ~pF_q;
    assign frame_end   = ~rF_q & pF_q;
    assign counted_end = frame_end & ((state_q == S_RUN) | (state_q == S_DRAIN));

    // iEnd takes priority over iStart and over a coincident frame start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!iEnd && iStart) state_d = S_ARMED;
            S_ARMED: if (iEnd) state_d = S_IDLE;
                     else if (frame_start) state_d = S_RUN;
            S_RUN:   if (iEnd) state_d = S_DRAIN;
            S_DRAIN: if (frame_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cap_c  = (state_q == S_RUN) | (state_q == S_DRAIN) |
                    ((state_q == S_ARMED) & frame_start & ~iEnd);
    assign fval_c = rF_q & cap_c;
    assign dval_c = fval_c & rL_q;

    // x_q/y_q hold the coordinate of the next pixel; a frame start forces it to (0,0).
    assign cur_x = frame_start ? 16'd0 : x_q;
    assign cur_y = frame_start ? 16'd0 : y_q;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        oX_d = oX_q;
        oY_d = oY_q;
        if (dval_c) begin
            oX_d = cur_x;
            oY_d = cur_y;
            if (cur_x == X_LAST) begin
                x_d = 16'd0;
                y_d = cur_y + 16'd1;
            end else begin
                x_d = cur_x + 16'd1;
                y_d = cur_y;
            end
        end else if (frame_start && cap_c) begin
            x_d = 16'd0;
            y_d = 16'd0;
        end
    end

    assign frm_d = counted_end ? frm_q + 32'd1 : frm_q;

    always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            oDATA_q <= '0;
            oDVAL_q <= 1'b0;
            oFval_q <= 1'b0;
            oX_q    <= '0;
            oY_q    <= '0;
            frm_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            oDATA_q <= rD_q;
            oDVAL_q <= dval_c;
            oFval_q <= fval_c;
            oX_q    <= oX_d;
            oY_q    <= oY_d;
            frm_q   <= frm_d;
        end
    end

`ifdef CCD_CAPTURE_GEOM_CHECK_EN
    localparam logic [23:0] PIX_EXP = 24'(H_ACTIVE * V_ACTIVE);

    logic [23:0] pix_cnt_q, pix_cnt_d;
    logic        err_q, err_d;

    // The last valid pixel precedes the frame-end cycle, so pix_cnt_q is complete when compared.
    always_comb begin
        pix_cnt_d = frame_start ? {23'd0, dval_c} : pix_cnt_q + {23'd0, dval_c};
        err_d     = err_q;
        if (state_q == S_IDLE && iStart && !iEnd) begin
            err_d = 1'b0;
        end else if (counted_end && pix_cnt_q != PIX_EXP) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            pix_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            err_q     <= err_d;
        end
    end

    assign oFrameErr = err_q;
`else
    assign oFrameErr = 1'b0;
`endif

    assign oDATA       = oDATA_q;
    assign oDVAL       = oDVAL_q;
    assign oFval       = oFval_q;
    assign oX_Cont     = oX_q;
    assign oY_Cont     = oY_q;
    assign oFrame_Cont = frm_q;
    assign oCapturing  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Directed bench for ccd_frame_capture using a reduced 8x4 frame geometry.
// A background monitor gathers pixel statistics; each scenario task checks them against hand-derived values.
module tb_ccd_frame_capture;

    localparam int H = 8;
    localparam int V = 4;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] iDATA;
    logic          iFVAL, iLVAL, iStart, iEnd;
    logic [DW-1:0] oDATA;
    logic          oDVAL, oFval, oCapturing, oFrameErr;
    logic [15:0]   oX_Cont, oY_Cont;
    logic [31:0]   oFrame_Cont;

    int n_tests = 0;
    int n_fail  = 0;

    int mon_n, first_x, first_y, last_x, last_y, seq_bad;

`ifdef CCD_CAPTURE_GEOM_CHECK_EN
    localparam logic GEOM_ON = 1'b1;
`else
    localparam logic GEOM_ON = 1'b0;
`endif

    ccd_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW)) dut (
        .CCD_PIXCLK (clk),
        .iRst_n     (rst_n),
        .iDATA      (iDATA),
        .iFVAL      (iFVAL),
        .iLVAL      (iLVAL),
        .iStart     (iStart),
        .iEnd       (iEnd),
        .oDATA      (oDATA),
        .oDVAL      (oDVAL),
        .oFval      (oFval),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFrame_Cont(oFrame_Cont),
        .oCapturing (oCapturing),
        .oFrameErr  (oFrameErr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int l, input int p);
        return DW'(l * 37 + p * 5 + 1);
    endfunction

    // Pixel statistics: count, first/last coordinate and raster-order violations.
    always @(negedge clk) begin
        int ex, ey;
        if (oDVAL === 1'b1) begin
            if (mon_n == 0) begin
                ex = 0;
                ey = 0;
                first_x = int'(oX_Cont);
                first_y = int'(oY_Cont);
            end else begin
                ex = (last_x == H - 1) ? 0 : last_x + 1;
                ey = (last_x == H - 1) ? last_y + 1 : last_y;
            end
            if (oX_Cont !== 16'(ex) || oY_Cont !== 16'(ey) || oDATA !== pat(ey, ex))
                seq_bad++;
            last_x = int'(oX_Cont);
            last_y = int'(oY_Cont);
            mon_n++;
        end
    end

    task automatic clr_mon();
        @(posedge clk);
        #1;
        mon_n = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1; seq_bad = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic e);
        @(negedge clk);
        iStart = s; iEnd = e;
        @(negedge clk);
        iStart = 1'b0; iEnd = 1'b0;
    endtask

    // ev: 0 none, 1 pulse iEnd, 2 pulse iStart, 3 assert reset (frame abandoned)
    task automatic drive_frame(input int lines, input int pix, input int ev,
                               input int ev_l, input int ev_p);
        @(negedge clk);
        iFVAL = 1'b1; iLVAL = 1'b0;
        @(negedge clk);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < pix; p++) begin
                @(negedge clk);
                iLVAL = 1'b1; iDATA = pat(l, p); iStart = 1'b0; iEnd = 1'b0;
                if (l == ev_l && p == ev_p) begin
                    if (ev == 1) iEnd = 1'b1;
                    if (ev == 2) iStart = 1'b1;
                    if (ev == 3) begin
                        rst_n = 1'b0;
                        return;
                    end
                end
            end
            @(negedge clk);
            iLVAL = 1'b0; iStart = 1'b0; iEnd = 1'b0; iDATA = '0;
            @(negedge clk);
        end
        @(negedge clk);
        iFVAL = 1'b0;
        idle(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iDATA = '1; iFVAL = 1'b1; iLVAL = 1'b1; iStart = 1'b0; iEnd = 1'b0;
        idle(3);
        n_tests++; if (oDVAL !== 1'b0) begin n_fail++; $display("FAIL reset_dval got %b want 0", oDVAL); end
        n_tests++; if (oFval !== 1'b0) begin n_fail++; $display("FAIL reset_fval got %b want 0", oFval); end
        n_tests++; if (oDATA !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", oDATA); end
        n_tests++; if (oFrame_Cont !== 32'd0) begin n_fail++; $display("FAIL reset_frames got %0d want 0", oFrame_Cont); end
        n_tests++; if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL reset_capturing got %b want 0", oCapturing); end
        n_tests++; if (oFrameErr !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", oFrameErr); end
        iDATA = '0; iFVAL = 1'b0; iLVAL = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        n_tests++; if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL reset_waits_idle got %b want 0", oCapturing); end
    endtask

    task automatic test_idle_no_capture();
        clr_mon();
        drive_frame(V, H, 0, 0, 0);
        n_tests++; if (mon_n !== 0) begin n_fail++; $display("FAIL idle_dval_count got %0d want 0", mon_n); end
        n_tests++; if (oFrame_Cont !== 32'd0) begin n_fail++; $display("FAIL idle_frames got %0d want 0", oFrame_Cont); end
    endtask

    task automatic test_start_full_frame();
        pulse(1'b1, 1'b0);
        n_tests++; if (oCapturing !== 1'b1) begin n_fail++; $display("FAIL armed_capturing got %b want 1", oCapturing); end
        clr_mon();
        drive_frame(V, H, 0, 0, 0);
        n_tests++; if (mon_n !== H * V) begin n_fail++; $display("FAIL full_dval_count got %0d want %0d", mon_n, H * V); end
        n_tests++; if (first_x !== 0 || first_y !== 0) begin n_fail++; $display("FAIL full_first got (%0d,%0d) want (0,0)", first_x, first_y); end
        n_tests++; if (last_x !== H - 1 || last_y !== V - 1) begin n_fail++; $display("FAIL full_last got (%0d,%0d) want (%0d,%0d)", last_x, last_y, H - 1, V - 1); end
        n_tests++; if (seq_bad !== 0) begin n_fail++; $display("FAIL full_raster_order got %0d bad want 0", seq_bad); end
        n_tests++; if (oFrame_Cont !== 32'd1) begin n_fail++; $display("FAIL full_frames got %0d want 1", oFrame_Cont); end
        n_tests++; if (oFrameErr !== 1'b0) begin n_fail++; $display("FAIL full_err got %b want 0", oFrameErr); end
        n_tests++; if (oFval !== 1'b0) begin n_fail++; $display("FAIL full_fval_after got %b want 0", oFval); end
    endtask

    task automatic test_back_to_back();
        clr_mon();
        drive_frame(V, H, 0, 0, 0);
        n_tests++; if (mon_n !== H * V) begin n_fail++; $display("FAIL b2b_dval_count got %0d want %0d", mon_n, H * V); end
        n_tests++; if (first_x !== 0 || first_y !== 0) begin n_fail++; $display("FAIL b2b_first got (%0d,%0d) want (0,0)", first_x, first_y); end
        n_tests++; if (seq_bad !== 0) begin n_fail++; $display("FAIL b2b_raster_order got %0d bad want 0", seq_bad); end
        n_tests++; if (oFrame_Cont !== 32'd2) begin n_fail++; $display("FAIL b2b_frames got %0d want 2", oFrame_Cont); end
    endtask

    task automatic test_end_midframe();
        clr_mon();
        drive_frame(V, H, 1, 2, 3);
        n_tests++; if (mon_n !== H * V) begin n_fail++; $display("FAIL end_dval_count got %0d want %0d", mon_n, H * V); end
        n_tests++; if (last_x !== H - 1 || last_y !== V - 1) begin n_fail++; $display("FAIL end_last got (%0d,%0d) want (%0d,%0d)", last_x, last_y, H - 1, V - 1); end
        n_tests++; if (oFrame_Cont !== 32'd3) begin n_fail++; $display("FAIL end_frames got %0d want 3", oFrame_Cont); end
        n_tests++; if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL end_idle got %b want 0", oCapturing); end
        clr_mon();
        drive_frame(V, H, 0, 0, 0);
        n_tests++; if (mon_n !== 0) begin n_fail++; $display("FAIL end_next_dval got %0d want 0", mon_n); end
        n_tests++; if (oFrame_Cont !== 32'd3) begin n_fail++; $display("FAIL end_next_frames got %0d want 3", oFrame_Cont); end
    endtask

    task automatic test_start_end_idle();
        pulse(1'b1, 1'b1);
        n_tests++; if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL both_capturing got %b want 0", oCapturing); end
        clr_mon();
        drive_frame(V, H, 0, 0, 0);
        n_tests++; if (mon_n !== 0) begin n_fail++; $display("FAIL both_dval_count got %0d want 0", mon_n); end
    endtask

    task automatic test_start_midframe();
        clr_mon();
        drive_frame(V, H, 2, 1, 2);
        n_tests++; if (mon_n !== 0) begin n_fail++; $display("FAIL midstart_dval got %0d want 0", mon_n); end
        n_tests++; if (oFrame_Cont !== 32'd3) begin n_fail++; $display("FAIL midstart_frames got %0d want 3", oFrame_Cont); end
        n_tests++; if (oCapturing !== 1'b1) begin n_fail++; $display("FAIL midstart_armed got %b want 1", oCapturing); end
        clr_mon();
        drive_frame(V, H, 1, 3, 0);
        n_tests++; if (mon_n !== H * V) begin n_fail++; $display("FAIL midstart_next_dval got %0d want %0d", mon_n, H * V); end
        n_tests++; if (first_x !== 0 || first_y !== 0) begin n_fail++; $display("FAIL midstart_first got (%0d,%0d) want (0,0)", first_x, first_y); end
        n_tests++; if (oFrame_Cont !== 32'd4) begin n_fail++; $display("FAIL midstart_next_frames got %0d want 4", oFrame_Cont); end
    endtask

    task automatic test_reset_midframe();
        pulse(1'b1, 1'b0);
        drive_frame(V, H, 3, 2, 4);
        #1;
        n_tests++; if (oDVAL !== 1'b0 || oFval !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valids got dval=%b fval=%b want 0", oDVAL, oFval); end
        n_tests++; if (oX_Cont !== 16'd0 || oY_Cont !== 16'd0) begin n_fail++; $display("FAIL rst_mid_xy got (%0d,%0d) want (0,0)", oX_Cont, oY_Cont); end
        n_tests++; if (oFrame_Cont !== 32'd0) begin n_fail++; $display("FAIL rst_mid_frames got %0d want 0", oFrame_Cont); end
        n_tests++; if (oCapturing !== 1'b0 || oDATA !== '0) begin n_fail++; $display("FAIL rst_mid_misc got cap=%b data=%h want 0", oCapturing, oDATA); end
        iFVAL = 1'b0; iLVAL = 1'b0; iDATA = '0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        pulse(1'b1, 1'b0);
        clr_mon();
        drive_frame(V, H, 0, 0, 0);
        n_tests++; if (mon_n !== H * V) begin n_fail++; $display("FAIL rst_resume_dval got %0d want %0d", mon_n, H * V); end
        n_tests++; if (first_x !== 0 || first_y !== 0) begin n_fail++; $display("FAIL rst_resume_first got (%0d,%0d) want (0,0)", first_x, first_y); end
        n_tests++; if (oFrame_Cont !== 32'd1) begin n_fail++; $display("FAIL rst_resume_frames got %0d want 1", oFrame_Cont); end
    endtask

    task automatic test_geom();
        clr_mon();
        drive_frame(V - 1, H, 0, 0, 0);
        n_tests++; if (mon_n !== H * (V - 1)) begin n_fail++; $display("FAIL geom_short_dval got %0d want %0d", mon_n, H * (V - 1)); end
        n_tests++; if (oFrameErr !== GEOM_ON) begin n_fail++; $display("FAIL geom_short_err got %b want %b", oFrameErr, GEOM_ON); end
        n_tests++; if (oFrame_Cont !== 32'd2) begin n_fail++; $display("FAIL geom_short_frames got %0d want 2", oFrame_Cont); end
        drive_frame(V, H, 1, 0, 1);
        n_tests++; if (oFrameErr !== GEOM_ON) begin n_fail++; $display("FAIL geom_sticky_err got %b want %b", oFrameErr, GEOM_ON); end
        n_tests++; if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL geom_idle got %b want 0", oCapturing); end
        pulse(1'b1, 1'b0);
        n_tests++; if (oFrameErr !== 1'b0) begin n_fail++; $display("FAIL geom_clear_err got %b want 0", oFrameErr); end
        pulse(1'b0, 1'b1);
        n_tests++; if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL geom_armed_end got %b want 0", oCapturing); end
    endtask

    initial begin
        test_reset();
        test_idle_no_capture();
        test_start_full_frame();
        test_back_to_back();
        test_end_midframe();
        test_start_end_idle();
        test_start_midframe();
        test_reset_midframe();
        test_geom();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
